// File: rtl/program_sequencer.sv
// Instruction sequencer for simple_cpu: a loadable program store feeding one
// instruction at a time, held CPI cycles, with run/step/abort/HALT control.
module program_sequencer #(
  parameter int                     INSTR_WIDTH = 20,
  parameter int                     PC_BITS     = 5,
  parameter int                     CPI         = 3,
  parameter logic [3:0]             HALT_OPCODE = 4'hF,
  parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_en,
  input  logic [PC_BITS-1:0]     load_addr,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic                   start,
  input  logic                   step_mode,
  input  logic                   step,
  input  logic                   abort,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   cpu_rst,
  output logic [PC_BITS-1:0]     pc,
  output logic                   busy,
  output logic                   done,
  output logic                   wrapped
);

  localparam int CNT_W = (CPI > 1) ? $clog2(CPI) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CPI - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [PC_BITS-1:0] PC_LAST  = '1;
  localparam logic [PC_BITS-1:0] PC_ONE   = PC_BITS'(1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CPURST = 3'd1;
  localparam logic [2:0] FETCH  = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] PAUSE  = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  logic [2:0]             state_q, state_d;
  logic [INSTR_WIDTH-1:0] instruction_q, instruction_d;
  logic [PC_BITS-1:0]     pc_q, pc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   cpu_rst_q, cpu_rst_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   wrapped_q, wrapped_d;

  // Program store survives rst so a program can be rerun after a reset.
  logic [INSTR_WIDTH-1:0] store_mem [2**PC_BITS];
  logic [INSTR_WIDTH-1:0] fetch_word;
  logic                   store_we;

  assign store_we   = load_en && (state_q == IDLE) && !abort;
  assign fetch_word = store_mem[pc_q];

  always_ff @(posedge clk) begin
    if (store_we) begin
      store_mem[load_addr] <= load_data;
    end
  end

  always_comb begin
    state_d       = state_q;
    instruction_d = instruction_q;
    pc_d          = pc_q;
    cnt_d         = cnt_q;
    wrapped_d     = wrapped_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d       = CPURST;
          pc_d          = '0;
          wrapped_d     = 1'b0;
          instruction_d = NOP_WORD;
        end
      end
      CPURST: state_d = FETCH;
      FETCH: begin
        if (fetch_word[INSTR_WIDTH-1 -: 4] == HALT_OPCODE) begin
          state_d       = DONE;
          instruction_d = NOP_WORD;
        end else begin
          state_d       = EXEC;
          instruction_d = fetch_word;
          cnt_d         = '0;
        end
      end
      EXEC: begin
        if (cnt_q == CNT_LAST) begin
          // Last address ends the run rather than wrapping back to 0.
          if (pc_q == PC_LAST) begin
            state_d       = DONE;
            wrapped_d     = 1'b1;
            instruction_d = NOP_WORD;
          end else begin
            pc_d = pc_q + PC_ONE;
            if (step_mode) begin
              state_d       = PAUSE;
              instruction_d = NOP_WORD;
            end else begin
              state_d = FETCH;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PAUSE: begin
        instruction_d = NOP_WORD;
        if (step || !step_mode) begin
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) begin
      state_d       = IDLE;
      instruction_d = NOP_WORD;
    end
    cpu_rst_d = (state_d == CPURST);
    busy_d    = (state_d == CPURST) || (state_d == FETCH) ||
                (state_d == EXEC)   || (state_d == PAUSE);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      instruction_q <= NOP_WORD;
      pc_q          <= '0;
      cnt_q         <= '0;
      cpu_rst_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      wrapped_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      instruction_q <= instruction_d;
      pc_q          <= pc_d;
      cnt_q         <= cnt_d;
      cpu_rst_q     <= cpu_rst_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      wrapped_q     <= wrapped_d;
    end
  end

  assign instruction = instruction_q;
  assign cpu_rst     = cpu_rst_q;
  assign pc          = pc_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign wrapped     = wrapped_q;

endmodule
